pcie_ingress: RTL and testbench
===============================

Name: pcie_ingress

Overview:
- Host-to-device TLP receiver; the inbound counterpart of the egress TLP builder.
- Accepts 32-bit AXI-stream beats from the PCIe core and parses the 3DW or 4DW header.
- Presents decoded header fields with a one-cycle strobe per packet.
- Streams payload dwords (CplD, MWr) into the incoming ping-pong FIFO write port. MRd and Cpl packets are reported only; no FIFO activity.

Parameters:
- none (all TLP encodings from the shared defines)

Ports:
- clk  in  1  clock
- rst  in  1  reset; rst synchronous, active-high; clock clk
- i_axi_ingress_data  in  32  TLP dword, big-endian header layout
- i_axi_ingress_keep  in  4  ignored; all beats treated as full dwords
- i_axi_ingress_last  in  1  final beat of TLP
- i_axi_ingress_valid  in  1  beat valid
- o_axi_ingress_ready  out  1  beat accept
- o_pkt_stb  out  1  header decoded, fields valid (one cycle)
- o_err_stb  out  1  malformed/unsupported packet (one cycle)
- o_command  out  8  fmt/type byte DW0[31:24]
- o_flags  out  14  DW0[23:10]
- o_dword_cnt  out  11  payload length, 1..1024 (length field 0 maps to 1024)
- o_requester_id  out  16  requester id
- o_tag  out  8  tag
- o_address  out  32  low 32 address bits (MRd/MWr); for Cpl, {25'h0, lower_addr[6:0]}
- o_cpl_status  out  3  completion status (Cpl/CplD); 0 otherwise
- o_byte_count  out  12  completion byte count; 0 otherwise
- i_fifo_rdy  in  1  a FIFO window is available
- o_fifo_act  out  1  window owned
- i_fifo_size  in  24  dwords in granted window
- o_fifo_data  out  32  payload dword
- o_fifo_stb  out  1  write strobe

Behaviour:
- Reset values: every output 0. Fields hold their last value until the next header.
- States: IDLE, HDR, WAIT_FIFO, DATA, DRAIN, REPORT.
- IDLE: ready=1. An accepted beat is captured as DW0; r_hdr_index=1; go to HDR.
- Header size is 4 if DW0[29]=1, else 3. Payload is present if DW0[30]=1.
- HDR: ready=1. DW1/DW2/DW3 captured by index.
  - MRd/MWr: DW1={req_id,tag,BE}; DW2 is the address. For 4DW headers the address is DW3, and DW2 (upper) is discarded.
  - Cpl/CplD: DW1={cpl_id,status,BCM,byte_count}; DW2={req_id,tag,r,lower_addr}.
  - last on a beat before the header completes: o_err_stb, no o_pkt_stb, go to IDLE.
- On the final header beat:
  - Supported types are MRd32/64, MWr32/64, Cpl, CplD. Any other type goes to DRAIN with the error flagged (or o_err_stb at once if last was set).
  - No payload and last=1: go to REPORT.
  - No payload and last=0: go to DRAIN (error).
  - Payload and last=1: o_err_stb, go to IDLE.
  - Otherwise: go to WAIT_FIFO.
- REPORT: o_pkt_stb=1 for one cycle, ready=0, then IDLE. Header-only latency: last beat accepted at N, o_pkt_stb at N+1.
- Payload packets assert o_pkt_stb in the cycle after the last header beat, before payload flows.
- WAIT_FIFO: ready=0. When i_fifo_rdy && !o_fifo_act: o_fifo_act<=1, r_fifo_cnt<=0, go to DATA.
- DATA:
  - ready = o_fifo_act && (r_fifo_cnt < i_fifo_size).
  - Each accepted beat produces o_fifo_data/o_fifo_stb registered, at N+1. r_fifo_cnt and r_data_cnt both increment.
  - Window full (r_fifo_cnt+1 == i_fifo_size on an accepted beat) with payload remaining: o_fifo_act<=0, back to WAIT_FIFO.
  - r_data_cnt+1 == dword_cnt: o_fifo_act<=0.
    - If last=1, go to IDLE.
    - If last=0, go to DRAIN (error, excess beats).
  - last before the count is reached: o_err_stb, o_fifo_act<=0, go to IDLE. Dwords already written stay written.
- DRAIN: ready=1. Beats are discarded. On last, o_err_stb<=1 and go to IDLE.
- Counters are 11 bits, so a 1024-dword payload needs no wrap.
- An unaccepted valid beat must not advance any state.
- rst during any state: immediately IDLE, o_fifo_act=0, partial packet dropped. The next accepted beat is treated as DW0.

Decomposition:
- Type codes (MRD_32B/64B, MWR_32B/64B, CPL, CPLD), DW0 bit ranges and the length-zero rule go in the shared pcie_defines.v; add CPL/CPLD and any missing ranges there.
- Optional sub-module pcie_ingress_hdr_decode: combinational classification of DW0 (hdr size, has_data, supported, dword_cnt).

Test Plan:
- MRd32 DW0=0x00000001, DW1=0x01A0_05_0F, DW2=0x00001000, last on DW2: o_pkt_stb one cycle after last, command=0x00, req_id=0x01A0, tag=0x05, address=0x1000, dword_cnt=1, no o_fifo_stb.
- CplD length 4, status 0, byte_count 16, i_fifo_size=64, payload 0x11..0x44: pkt_stb, then 4 fifo strobes with data in order, o_fifo_act drops after the 4th.
- MWr64 length 8 with i_fifo_size=3: fifo windows of 3, 3, 2; o_fifo_act toggles; ready low while waiting; all 8 dwords written in order.
- CplD length 4 with last on the 2nd payload beat: 2 strobes, o_err_stb, back to IDLE. Length 2 with 4 payload beats: 2 strobes, then DRAIN, o_err_stb on last.
- Unsupported type 0x04 (CfgRd) with 3DW: all beats accepted and discarded, o_err_stb, no o_pkt_stb. Valid held with ready never stalling.
- rst asserted during DATA: outputs 0 next cycle. A following MRd32 decodes correctly.

Source files
------------

// File: rtl/pcie_ingress_pkg.sv
// Shared TLP encodings, DW0 field positions and ingress types.
// Imported by the ingress interface, header decoder and top.
package pcie_ingress_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned KEEP_W      = 4;
  localparam int unsigned CMD_W       = 8;
  localparam int unsigned FLAGS_W     = 14;
  localparam int unsigned LEN_W       = 10;
  localparam int unsigned CNT_W       = 11;
  localparam int unsigned FIFO_SIZE_W = 24;

  // fmt/type byte encodings (DW0[31:24])
  localparam logic [CMD_W-1:0] MRD_32B = 8'h00;
  localparam logic [CMD_W-1:0] MRD_64B = 8'h20;
  localparam logic [CMD_W-1:0] MWR_32B = 8'h40;
  localparam logic [CMD_W-1:0] MWR_64B = 8'h60;
  localparam logic [CMD_W-1:0] CPL     = 8'h0A;
  localparam logic [CMD_W-1:0] CPLD    = 8'h4A;

  // DW0 bit ranges
  localparam int unsigned DW0_CMD_HI   = 31;
  localparam int unsigned DW0_CMD_LO   = 24;
  localparam int unsigned DW0_FLAGS_HI = 23;
  localparam int unsigned DW0_FLAGS_LO = 10;
  localparam int unsigned DW0_LEN_HI   = 9;
  localparam int unsigned DW0_LEN_LO   = 0;

  // fmt bits as seen inside the command byte (DW0[29] and DW0[30])
  localparam int unsigned CMD_4DW_BIT  = 5;
  localparam int unsigned CMD_DATA_BIT = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WAIT_FIFO,
    ST_DATA,
    ST_DRAIN,
    ST_REPORT
  } state_t;

  // Decoded header fields presented to the user logic
  typedef struct packed {
    logic [CMD_W-1:0]   command;
    logic [FLAGS_W-1:0] flags;
    logic [CNT_W-1:0]   dword_cnt;
    logic [15:0]        requester_id;
    logic [7:0]         tag;
    logic [31:0]        address;
    logic [2:0]         cpl_status;
    logic [11:0]        byte_count;
  } hdr_fields_t;

  // A length field of zero encodes the maximum payload of 1024 dwords
  function automatic logic [CNT_W-1:0] len_to_dwords(input logic [LEN_W-1:0] len);
    return (len == '0) ? CNT_W'(1024) : CNT_W'(len);
  endfunction

endpackage

// File: rtl/pcie_ingress_if.sv
// AXI-stream beat bus from the PCIe core into the ingress parser.
//   data  : TLP dword, big-endian header layout
//   keep  : byte enables (ignored by the parser)
//   last  : final beat of a TLP
//   valid : beat valid (source)
//   ready : beat accept (sink)
interface pcie_ingress_if;
  import pcie_ingress_pkg::*;

  logic [DATA_W-1:0] data;
  logic [KEEP_W-1:0] keep;
  logic              last;
  logic              valid;
  logic              ready;

  modport master (output data, keep, last, valid, input ready);
  modport slave  (input data, keep, last, valid, output ready);

endinterface

// File: rtl/pcie_ingress_hdr_decode.sv
// Combinational classification of a TLP from its DW0 fields.
//   command     : DW0[31:24] fmt/type byte
//   len         : DW0[9:0] length field
//   hdr_4dw_c   : header is 4 dwords
//   has_data_c  : payload follows the header
//   supported_c : MRd32/64, MWr32/64, Cpl, CplD
//   is_cpl_c    : completion layout for DW1/DW2
//   dword_cnt_c : payload length in dwords, 1..1024
module pcie_ingress_hdr_decode
  import pcie_ingress_pkg::*;
(
  input  logic [CMD_W-1:0] command,
  input  logic [LEN_W-1:0] len,
  output logic             hdr_4dw_c,
  output logic             has_data_c,
  output logic             supported_c,
  output logic             is_cpl_c,
  output logic [CNT_W-1:0] dword_cnt_c
);

  assign hdr_4dw_c   = command[CMD_4DW_BIT];
  assign has_data_c  = command[CMD_DATA_BIT];
  assign is_cpl_c    = (command == CPL) || (command == CPLD);
  assign dword_cnt_c = len_to_dwords(len);

  always_comb begin
    supported_c = 1'b0;
    case (command)
      MRD_32B, MRD_64B, MWR_32B, MWR_64B, CPL, CPLD: supported_c = 1'b1;
      default: supported_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/pcie_ingress.sv
// Host-to-device TLP receiver: parses 3DW/4DW headers from the AXI-stream
// ingress, presents decoded fields with a one-cycle strobe and streams
// payload dwords into the incoming ping-pong FIFO write port.
//   clk, rst        : clock, synchronous active-high reset
//   axi_ingress     : beat bus from the PCIe core (slave side)
//   o_pkt_stb       : header decoded, fields valid (one cycle)
//   o_err_stb       : malformed/unsupported packet (one cycle)
//   o_command..o_byte_count : decoded header fields, held until next header
//   i_fifo_rdy      : a FIFO window is available
//   o_fifo_act      : window owned
//   i_fifo_size     : dwords in the granted window
//   o_fifo_data/stb : payload dword and write strobe
module pcie_ingress
  import pcie_ingress_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  pcie_ingress_if.slave          axi_ingress,
  output logic                   o_pkt_stb,
  output logic                   o_err_stb,
  output logic [CMD_W-1:0]       o_command,
  output logic [FLAGS_W-1:0]     o_flags,
  output logic [CNT_W-1:0]       o_dword_cnt,
  output logic [15:0]            o_requester_id,
  output logic [7:0]             o_tag,
  output logic [31:0]            o_address,
  output logic [2:0]             o_cpl_status,
  output logic [11:0]            o_byte_count,
  input  logic                   i_fifo_rdy,
  output logic                   o_fifo_act,
  input  logic [FIFO_SIZE_W-1:0] i_fifo_size,
  output logic [DATA_W-1:0]      o_fifo_data,
  output logic                   o_fifo_stb
);

  state_t            state;
  logic [1:0]        hdr_index;
  logic [DATA_W-1:0] dw0;
  logic [DATA_W-1:0] dw1;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  data_cnt;
  hdr_fields_t       fields;
  hdr_fields_t       hdr_next_c;

  logic              hdr_4dw_c;
  logic              has_data_c;
  logic              supported_c;
  logic              is_cpl_c;
  logic [CNT_W-1:0]  dword_cnt_c;
  logic [1:0]        hdr_last_c;
  logic              ready_c;
  logic              accept_c;
  logic              window_full_c;
  logic              payload_done_c;

  // keep is ignored and DW1 BCM is not reported
  logic unused_bits;
  assign unused_bits = ^{axi_ingress.keep, dw1[12]};

  // Classification always works on the captured DW0
  pcie_ingress_hdr_decode u_hdr_decode (
    .command     (dw0[DW0_CMD_HI:DW0_CMD_LO]),
    .len         (dw0[DW0_LEN_HI:DW0_LEN_LO]),
    .hdr_4dw_c   (hdr_4dw_c),
    .has_data_c  (has_data_c),
    .supported_c (supported_c),
    .is_cpl_c    (is_cpl_c),
    .dword_cnt_c (dword_cnt_c)
  );

  assign hdr_last_c = hdr_4dw_c ? 2'd3 : 2'd2;

  // Beat accept: open in header/drain states, window-limited in DATA
  always_comb begin
    ready_c = 1'b0;
    case (state)
      ST_IDLE, ST_HDR, ST_DRAIN: ready_c = 1'b1;
      ST_DATA: ready_c = o_fifo_act && (FIFO_SIZE_W'(fifo_cnt) < i_fifo_size);
      default: ready_c = 1'b0;
    endcase
    if (rst) ready_c = 1'b0;
  end

  assign axi_ingress.ready = ready_c;
  assign accept_c          = axi_ingress.valid && ready_c;
  assign window_full_c     = (FIFO_SIZE_W'(fifo_cnt) + FIFO_SIZE_W'(1)) == i_fifo_size;
  assign payload_done_c    = (data_cnt + CNT_W'(1)) == fields.dword_cnt;

  // Field assembly on the final header beat. The final beat is always the
  // address (DW2 for 3DW, DW3 for 4DW) or, for completions, DW2.
  always_comb begin
    hdr_next_c           = '0;
    hdr_next_c.command   = dw0[DW0_CMD_HI:DW0_CMD_LO];
    hdr_next_c.flags     = dw0[DW0_FLAGS_HI:DW0_FLAGS_LO];
    hdr_next_c.dword_cnt = dword_cnt_c;
    if (is_cpl_c) begin
      hdr_next_c.requester_id = axi_ingress.data[31:16];
      hdr_next_c.tag          = axi_ingress.data[15:8];
      hdr_next_c.address      = {25'h0, axi_ingress.data[6:0]};
      hdr_next_c.cpl_status   = dw1[15:13];
      hdr_next_c.byte_count   = dw1[11:0];
    end else begin
      hdr_next_c.requester_id = dw1[31:16];
      hdr_next_c.tag          = dw1[15:8];
      hdr_next_c.address      = axi_ingress.data;
    end
  end

  // Parser state machine with registered strobes and FIFO control
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      hdr_index   <= '0;
      dw0         <= '0;
      dw1         <= '0;
      fifo_cnt    <= '0;
      data_cnt    <= '0;
      fields      <= '0;
      o_pkt_stb   <= 1'b0;
      o_err_stb   <= 1'b0;
      o_fifo_act  <= 1'b0;
      o_fifo_data <= '0;
      o_fifo_stb  <= 1'b0;
    end else begin
      o_pkt_stb  <= 1'b0;
      o_err_stb  <= 1'b0;
      o_fifo_stb <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            dw0       <= axi_ingress.data;
            hdr_index <= 2'd1;
            if (axi_ingress.last) o_err_stb <= 1'b1;
            else                  state     <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (accept_c) begin
            hdr_index <= hdr_index + 2'd1;
            if (hdr_index == 2'd1) dw1 <= axi_ingress.data;
            if (hdr_index != hdr_last_c) begin
              // truncated header
              if (axi_ingress.last) begin
                o_err_stb <= 1'b1;
                state     <= ST_IDLE;
              end
            end else if (!supported_c) begin
              if (axi_ingress.last) begin
                o_err_stb <= 1'b1;
                state     <= ST_IDLE;
              end else begin
                state <= ST_DRAIN;
              end
            end else if (!has_data_c) begin
              if (axi_ingress.last) begin
                fields    <= hdr_next_c;
                o_pkt_stb <= 1'b1;
                state     <= ST_REPORT;
              end else begin
                state <= ST_DRAIN;
              end
            end else if (axi_ingress.last) begin
              // payload announced but none follows
              o_err_stb <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              fields    <= hdr_next_c;
              o_pkt_stb <= 1'b1;
              data_cnt  <= '0;
              state     <= ST_WAIT_FIFO;
            end
          end
        end

        ST_REPORT: begin
          state <= ST_IDLE;
        end

        ST_WAIT_FIFO: begin
          if (i_fifo_rdy && !o_fifo_act) begin
            o_fifo_act <= 1'b1;
            fifo_cnt   <= '0;
            state      <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (accept_c) begin
            o_fifo_data <= axi_ingress.data;
            o_fifo_stb  <= 1'b1;
            fifo_cnt    <= fifo_cnt + CNT_W'(1);
            data_cnt    <= data_cnt + CNT_W'(1);
            if (payload_done_c) begin
              o_fifo_act <= 1'b0;
              state      <= axi_ingress.last ? ST_IDLE : ST_DRAIN;
            end else if (axi_ingress.last) begin
              // short payload; dwords already written stay written
              o_err_stb  <= 1'b1;
              o_fifo_act <= 1'b0;
              state      <= ST_IDLE;
            end else if (window_full_c) begin
              o_fifo_act <= 1'b0;
              state      <= ST_WAIT_FIFO;
            end
          end
        end

        ST_DRAIN: begin
          if (accept_c && axi_ingress.last) begin
            o_err_stb <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_command      = fields.command;
  assign o_flags        = fields.flags;
  assign o_dword_cnt    = fields.dword_cnt;
  assign o_requester_id = fields.requester_id;
  assign o_tag          = fields.tag;
  assign o_address      = fields.address;
  assign o_cpl_status   = fields.cpl_status;
  assign o_byte_count   = fields.byte_count;

endmodule

// File: tb/tb_pcie_ingress.sv
// Scoreboard bench for pcie_ingress: expected headers and payload dwords
// are queued as beats are driven and popped when the DUT strobes them.
module tb_pcie_ingress;

  logic        clk;
  logic        rst;
  logic        fifo_rdy;
  logic [23:0] fifo_size;

  logic        o_pkt_stb, o_err_stb, o_fifo_act, o_fifo_stb;
  logic [7:0]  o_command;
  logic [13:0] o_flags;
  logic [10:0] o_dword_cnt;
  logic [15:0] o_requester_id;
  logic [7:0]  o_tag;
  logic [31:0] o_address;
  logic [2:0]  o_cpl_status;
  logic [11:0] o_byte_count;
  logic [31:0] o_fifo_data;

  pcie_ingress_if axi ();

  pcie_ingress dut (
    .clk            (clk),
    .rst            (rst),
    .axi_ingress    (axi),
    .o_pkt_stb      (o_pkt_stb),
    .o_err_stb      (o_err_stb),
    .o_command      (o_command),
    .o_flags        (o_flags),
    .o_dword_cnt    (o_dword_cnt),
    .o_requester_id (o_requester_id),
    .o_tag          (o_tag),
    .o_address      (o_address),
    .o_cpl_status   (o_cpl_status),
    .o_byte_count   (o_byte_count),
    .i_fifo_rdy     (fifo_rdy),
    .o_fifo_act     (o_fifo_act),
    .i_fifo_size    (fifo_size),
    .o_fifo_data    (o_fifo_data),
    .o_fifo_stb     (o_fifo_stb)
  );

  typedef struct {
    logic [7:0]  command;
    logic [13:0] flags;
    logic [10:0] dword_cnt;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [31:0] addr;
    logic [2:0]  st;
    logic [11:0] bc;
  } exp_pkt_t;

  exp_pkt_t    exp_pkt[$];
  logic [31:0] exp_fifo[$];
  logic [31:0] tx[$];

  int checks = 0;
  int failures = 0;
  int pkt_seen = 0;
  int err_seen = 0;
  int act_rises = 0;
  int stall_cnt = 0;
  logic act_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(input logic [7:0] cmd, input logic [13:0] flags,
                          input logic [10:0] dcnt, input logic [15:0] rid,
                          input logic [7:0] tag, input logic [31:0] addr,
                          input logic [2:0] st, input logic [11:0] bc);
    exp_pkt_t e;
    e.command = cmd; e.flags = flags; e.dword_cnt = dcnt; e.rid = rid;
    e.tag = tag; e.addr = addr; e.st = st; e.bc = bc;
    exp_pkt.push_back(e);
  endtask

  task automatic hdr(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    tx.delete();
    tx.push_back(a);
    tx.push_back(b);
    tx.push_back(c);
  endtask

  // Called just after a falling edge; returns just after the next falling edge
  task automatic send_beat(input logic [31:0] d, input logic l, input logic pay);
    int waited;
    waited = 0;
    axi.data  = d;
    axi.last  = l;
    axi.valid = 1'b1;
    #1;
    while (!axi.ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    stall_cnt += waited;
    if (waited >= 200) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      if (pay) exp_fifo.push_back(d);
      @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_range(input int lo, input int hi, input int pay_lo, input int pay_hi);
    for (int i = lo; i < hi; i++)
      send_beat(tx[i], i == tx.size() - 1, i >= pay_lo && i < pay_hi);
  endtask

  task automatic idle_bus();
    axi.valid = 1'b0;
    axi.last  = 1'b0;
  endtask

  task automatic end_test(input string tag, input int pkts, input int errs, input int rises);
    idle_bus();
    repeat (4) @(negedge clk);
    check({tag, "_pkts"}, 32'(pkt_seen), 32'(pkts));
    check({tag, "_errs"}, 32'(err_seen), 32'(errs));
    check({tag, "_windows"}, 32'(act_rises), 32'(rises));
    check({tag, "_fifo_left"}, 32'(exp_fifo.size()), 32'd0);
    check({tag, "_pkt_left"}, 32'(exp_pkt.size()), 32'd0);
    pkt_seen  = 0;
    err_seen  = 0;
    act_rises = 0;
    exp_fifo.delete();
    exp_pkt.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_strobes"}, 32'({o_fifo_act, o_fifo_stb, o_pkt_stb, o_err_stb}), 32'd0);
    check({tag, "_cmd_flags"}, 32'({o_command, o_flags}), 32'd0);
    check({tag, "_dword_cnt"}, 32'(o_dword_cnt), 32'd0);
    check({tag, "_rid_tag"}, 32'({o_requester_id, o_tag}), 32'd0);
    check({tag, "_address"}, o_address, 32'd0);
    check({tag, "_cpl"}, 32'({o_cpl_status, o_byte_count}), 32'd0);
    check({tag, "_fifo_data"}, o_fifo_data, 32'd0);
    check({tag, "_ready"}, 32'(axi.ready), 32'd0);
  endtask

  // Output monitor: pops scoreboard entries on DUT strobes
  initial begin
    exp_pkt_t e;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (o_pkt_stb) begin
        pkt_seen++;
        if (exp_pkt.size() == 0) begin
          check("pkt_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_pkt.pop_front();
          check("pkt_command", 32'(o_command), 32'(e.command));
          check("pkt_flags", 32'(o_flags), 32'(e.flags));
          check("pkt_dword_cnt", 32'(o_dword_cnt), 32'(e.dword_cnt));
          check("pkt_requester_id", 32'(o_requester_id), 32'(e.rid));
          check("pkt_tag", 32'(o_tag), 32'(e.tag));
          check("pkt_address", o_address, e.addr);
          check("pkt_cpl_status", 32'(o_cpl_status), 32'(e.st));
          check("pkt_byte_count", 32'(o_byte_count), 32'(e.bc));
        end
      end
      if (o_fifo_stb) begin
        if (exp_fifo.size() == 0) begin
          check("fifo_unexpected", o_fifo_data, 32'hFFFF_FFFF);
        end else begin
          d = exp_fifo.pop_front();
          check("fifo_data", o_fifo_data, d);
        end
      end
      if (o_err_stb) err_seen++;
      if (o_fifo_act && !act_prev) act_rises++;
      act_prev = o_fifo_act;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    fifo_rdy  = 1'b1;
    fifo_size = 24'd64;
    axi.data  = '0;
    axi.keep  = 4'hF;
    idle_bus();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // MRd32, header only
    hdr(32'h0000_0001, 32'h01A0_050F, 32'h0000_1000);
    push_pkt(8'h00, 14'h0, 11'd1, 16'h01A0, 8'h05, 32'h0000_1000, 3'd0, 12'd0);
    send_range(0, 3, 0, 0);
    check("mrd_latency", 32'(o_pkt_stb), 32'd1);
    end_test("mrd32", 1, 0, 0);

    // CplD length 4 into a 64-dword window
    hdr(32'h4A00_0004, 32'h0100_0010, 32'h01A0_0700);
    for (int i = 1; i <= 4; i++) tx.push_back(32'(i * 'h11));
    push_pkt(8'h4A, 14'h0, 11'd4, 16'h01A0, 8'h07, 32'h0, 3'd0, 12'd16);
    send_range(0, 7, 3, 7);
    check("cpld_act_drop", 32'(o_fifo_act), 32'd0);
    end_test("cpld", 1, 0, 1);

    // MWr64 length 8 through windows of 3
    fifo_size = 24'd3;
    fifo_rdy  = 1'b0;
    hdr(32'h6000_1008, 32'hBEEF_2AFF, 32'h0000_0001);
    tx.push_back(32'hC0DE_0040);
    for (int i = 0; i < 8; i++) tx.push_back(32'hA000_0000 + 32'(i));
    push_pkt(8'h60, 14'h0004, 11'd8, 16'hBEEF, 8'h2A, 32'hC0DE_0040, 3'd0, 12'd0);
    send_range(0, 4, 4, 12);
    idle_bus();
    repeat (3) @(negedge clk);
    check("mwr_wait_ready", 32'(axi.ready), 32'd0);
    check("mwr_wait_act", 32'(o_fifo_act), 32'd0);
    fifo_rdy  = 1'b1;
    stall_cnt = 0;
    send_range(4, 12, 4, 12);
    check("mwr_stalls", 32'(stall_cnt), 32'd3);
    end_test("mwr64", 1, 0, 3);
    fifo_size = 24'd64;

    // CplD length 4 cut short after 2 payload beats
    hdr(32'h4A00_0004, 32'h0100_4008, 32'h1234_5611);
    tx.push_back(32'h55);
    tx.push_back(32'h66);
    push_pkt(8'h4A, 14'h0, 11'd4, 16'h1234, 8'h56, 32'h11, 3'd2, 12'd8);
    send_range(0, 5, 3, 5);
    check("short_act_drop", 32'(o_fifo_act), 32'd0);
    end_test("cpld_short", 1, 1, 1);

    // CplD length 2 with 4 payload beats
    hdr(32'h4A00_0002, 32'h0100_0008, 32'h01A0_0903);
    tx.push_back(32'h77);
    tx.push_back(32'h88);
    tx.push_back(32'h99);
    tx.push_back(32'hAA);
    push_pkt(8'h4A, 14'h0, 11'd2, 16'h01A0, 8'h09, 32'h3, 3'd0, 12'd8);
    send_range(0, 7, 3, 5);
    end_test("cpld_long", 1, 1, 1);

    // Unsupported CfgRd with trailing beats: drained without stalling
    hdr(32'h0400_0001, 32'h01A0_0A0F, 32'h0000_0010);
    tx.push_back(32'hDEAD_0001);
    tx.push_back(32'hDEAD_0002);
    stall_cnt = 0;
    send_range(0, 5, 0, 0);
    check("cfgrd_stalls", 32'(stall_cnt), 32'd0);
    end_test("cfgrd", 0, 1, 0);

    // Header truncated by last on DW1
    tx.delete();
    tx.push_back(32'h0000_0001);
    tx.push_back(32'h01A0_050F);
    send_range(0, 2, 0, 0);
    end_test("trunc", 0, 1, 0);

    // MWr32 with last on the final header beat (payload missing)
    hdr(32'h4000_0001, 32'h01A0_050F, 32'h0000_2000);
    send_range(0, 3, 0, 0);
    end_test("mwr_nopay", 0, 1, 0);

    // Reset in the middle of a CplD payload
    hdr(32'h4A00_0010, 32'h0100_0040, 32'h01A0_0B00);
    for (int i = 1; i <= 16; i++) tx.push_back(32'h5000_0000 + 32'(i));
    push_pkt(8'h4A, 14'h0, 11'd16, 16'h01A0, 8'h0B, 32'h0, 3'd0, 12'h040);
    send_range(0, 6, 3, 19);
    idle_bus();
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_data");
    rst = 1'b0;
    end_test("rst_data", 1, 0, 1);

    // MRd32 after reset, length field 0 meaning 1024 dwords
    hdr(32'h0000_0000, 32'h0042_0C0F, 32'h0000_ABC0);
    push_pkt(8'h00, 14'h0, 11'd1024, 16'h0042, 8'h0C, 32'h0000_ABC0, 3'd0, 12'd0);
    send_range(0, 3, 0, 0);
    check("len0_latency", 32'(o_pkt_stb), 32'd1);
    end_test("mrd_len0", 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
